uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Parametrised oversampling UART receiver; successor to the fixed 8N1 receiver.
//  Samples i_Rx_Serial at OVERSAMPLE ticks/bit (i_bd from the baud generator), validates start bit at mid-bit,
//  receives DATA_BITS LSB-first, optional parity, STOP_BITS stop bits; flags framing/parity errors.
//  Sits between the baud-rate generator and the RX FIFO / interface logic.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9
//  OVERSAMPLE  16  i_bd ticks per bit period, even, legal 8..32
//  STOP_BITS   1   stop bits checked, legal 1 or 2
//  PARITY_ODD  0   0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)
// PORTS
//  i_Clock       in   1          system clock, rising edge
//  i_reset       in   1          asynchronous active-high reset
//  i_bd          in   1          oversample tick, 1-cycle pulse, OVERSAMPLE per bit
//  i_Rx_Serial   in   1          asynchronous serial line, idle high
//  o_Rx_Done     out  1          1-cycle pulse: frame complete, o_Rx_Byte/error flags valid
//  o_Rx_Byte     out  DATA_BITS  received data, bit0 = first received; held until next o_Rx_Done
//  o_frame_err   out  1          stop bit sampled 0 in last frame; updated with o_Rx_Done
//  o_parity_err  out  1          parity mismatch in last frame; updated with o_Rx_Done
//  o_busy        out  1          high from start detect until return to IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, synchroniser flops 1. Reset mid-frame aborts, no o_Rx_Done.
//  - i_Rx_Serial through 2-flop synchroniser (rx_s); line seen 2 cycles late. Start = falling edge of rx_s.
//  - tick_cnt width $clog2(OVERSAMPLE), advances only on i_bd; bit_cnt width $clog2(DATA_BITS+1).
//  - IDLE: on falling edge of rx_s -> START, tick_cnt=0, o_busy=1. Low without edge (e.g. break) ignored.
//  - START: on tick with tick_cnt==OVERSAMPLE/2-1: rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0;
//    rx_s==1 -> false start, back to IDLE, no o_Rx_Done, no flags changed.
//  - DATA: sample rx_s on tick with tick_cnt==OVERSAMPLE-1 (mid-bit), shift in LSB-first;
//    after DATA_BITS samples -> PARITY (macro on) or STOP.
//  - PARITY: one bit, sampled same way; err = XOR(data,parity_bit) != PARITY_ODD.
//  - STOP: sample STOP_BITS bits; any 0 sets framing error. After last stop sample, same cycle:
//    o_Rx_Byte, o_frame_err, o_parity_err loaded, o_Rx_Done=1 for exactly one clock, -> IDLE.
//  - o_Rx_Done asserts 0.5 bit before end of last stop bit; next falling edge accepted from next cycle.
//  - Frame with framing error still delivered (data + o_frame_err=1). If line stays low, no new start until high->low.
//  - i_bd asserted in same cycle as start edge: not counted (counting starts next tick).
//  - No ready/backpressure: consumer must capture on o_Rx_Done; new frame overwrites outputs.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, frame = start+DATA_BITS+parity+stop, o_parity_err live.
//  Undefined: no PARITY state, frame = start+DATA_BITS+stop, o_parity_err tied 0, PARITY_ODD unused.
// STRUCTURE
//  Package uart_pkg: state encodings (IDLE, START, DATA, PARITY, STOP) as localparams, parity mode constants,
//  shared with the UART TX successor.
//  Sub-module uart_rx_sync: 2-flop synchroniser + falling-edge detect (reset value 1), reused by TX/loopback.
//  FSM, counters and shift register in uart_rx_os itself.
// TESTING (OVERSAMPLE=16, DATA_BITS=8, STOP_BITS=1 unless stated)
//  1. Send 0xA5 8N1 -> one o_Rx_Done pulse, o_Rx_Byte=0xA5, o_frame_err=0, o_busy low after pulse.
//  2. 0.3-bit low glitch on idle line -> START aborted at mid-bit, no o_Rx_Done, outputs unchanged.
//  3. Send 0x3C with stop bit forced 0 -> o_Rx_Byte=0x3C, o_frame_err=1; next valid 0x55 -> frame_err=0.
//  4. UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity 1 -> parity_err=0; with parity 0 -> parity_err=1.
//  5. DATA_BITS=7, STOP_BITS=2, 0x41 then back-to-back 0x7F, second frame's 2nd stop bit 0 -> 0x41 ok; 0x7F frame_err=1.
//  6. Assert i_reset during data bit 4 of 0xFF -> outputs 0 immediately, no o_Rx_Done; next 0x12 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants,
// common to the oversampling receiver and its transmit counterpart.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high serial line plus falling-edge detect.
// All flops reset to 1 so that reset never looks like a start edge.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_reset,
    input  logic i_serial,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_serial;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit start validation, LSB-first data, STOP_BITS stop
// bits, framing error flag. Define UART_RX_PARITY_EN to add the parity bit and o_parity_err.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_reset,
    input  logic                 i_bd,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_Done,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
        (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_os: illegal parameter combination");
    end

    logic w_rx_s;
    logic w_fall;

    uart_rx_sync u_sync (
        .i_Clock  (i_Clock),
        .i_reset  (i_reset),
        .i_serial (i_Rx_Serial),
        .o_rx_s   (w_rx_s),
        .o_fall   (w_fall)
    );

    uart_state_t          r_state,     w_state_nx;
    logic [TW-1:0]        r_tick,      w_tick_nx;
    logic [BW-1:0]        r_bit,       w_bit_nx;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nx;
    logic                 r_ferr_acc,  w_ferr_acc_nx;
    logic [DATA_BITS-1:0] r_byte,      w_byte_nx;
    logic                 r_frame_err, w_frame_err_nx;
    logic                 r_done,      w_done_nx;
    logic                 r_busy,      w_busy_nx;
`ifdef UART_RX_PARITY_EN
    logic                 r_perr_acc,  w_perr_acc_nx;
    logic                 r_parity_err, w_parity_err_nx;
    logic                 w_par_mode;
    assign w_par_mode = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;
`endif

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_ferr_acc  <= 1'b0;
            r_byte      <= '0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr_acc   <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_tick      <= w_tick_nx;
            r_bit       <= w_bit_nx;
            r_shift     <= w_shift_nx;
            r_ferr_acc  <= w_ferr_acc_nx;
            r_byte      <= w_byte_nx;
            r_frame_err <= w_frame_err_nx;
            r_done      <= w_done_nx;
            r_busy      <= w_busy_nx;
`ifdef UART_RX_PARITY_EN
            r_perr_acc   <= w_perr_acc_nx;
            r_parity_err <= w_parity_err_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_tick_nx      = r_tick;
        w_bit_nx       = r_bit;
        w_shift_nx     = r_shift;
        w_ferr_acc_nx  = r_ferr_acc;
        w_byte_nx      = r_byte;
        w_frame_err_nx = r_frame_err;
        w_done_nx      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_acc_nx   = r_perr_acc;
        w_parity_err_nx = r_parity_err;
`endif
        case (r_state)
            ST_IDLE: begin
                // Edge-triggered start: a line held low (break) never re-arms the receiver.
                if (w_fall) begin
                    w_state_nx = ST_START;
                    w_tick_nx  = '0;
                end
            end
            ST_START: begin
                if (i_bd) begin
                    if (r_tick == TICK_HALF) begin
                        w_tick_nx  = '0;
                        w_bit_nx   = '0;
                        w_state_nx = w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tick_nx = r_tick + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_bd) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nx  = '0;
                        w_shift_nx = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit == BIT_LAST) begin
                            w_bit_nx      = '0;
                            w_ferr_acc_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
                            w_state_nx = ST_PARITY;
`else
                            w_state_nx = ST_STOP;
`endif
                        end else begin
                            w_bit_nx = r_bit + 1'b1;
                        end
                    end else begin
                        w_tick_nx = r_tick + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_bd) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nx     = '0;
                        w_perr_acc_nx = ((^r_shift) ^ w_rx_s) != w_par_mode;
                        w_state_nx    = ST_STOP;
                    end else begin
                        w_tick_nx = r_tick + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_bd) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_nx = '0;
                        if (r_bit == STOP_LAST) begin
                            w_byte_nx      = r_shift;
                            w_frame_err_nx = r_ferr_acc | ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                            w_parity_err_nx = r_perr_acc;
`endif
                            w_done_nx  = 1'b1;
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_bit_nx      = r_bit + 1'b1;
                            w_ferr_acc_nx = r_ferr_acc | ~w_rx_s;
                        end
                    end else begin
                        w_tick_nx = r_tick + 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    assign o_Rx_Done   = r_done;
    assign o_Rx_Byte   = r_byte;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: default 8-bit/1-stop instance plus a 7-bit/2-stop instance.
module tb_uart_rx_os;

    localparam int BD_DIV   = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = BD_DIV * OS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bd  = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;

    logic       done_a, ferr_a, perr_a, busy_a;
    logic [7:0] byte_a;
    logic       done_b, ferr_b, perr_b, busy_b;
    logic [6:0] byte_b;

    int checks = 0;
    int errors = 0;
    int done0  = 0;
    int done1  = 0;
    int bd_cnt = 0;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .i_Clock(clk), .i_reset(rst), .i_bd(bd), .i_Rx_Serial(rx0),
        .o_Rx_Done(done_a), .o_Rx_Byte(byte_a), .o_frame_err(ferr_a),
        .o_parity_err(perr_a), .o_busy(busy_a)
    );

    uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
        .i_Clock(clk), .i_reset(rst), .i_bd(bd), .i_Rx_Serial(rx1),
        .o_Rx_Done(done_b), .o_Rx_Byte(byte_b), .o_frame_err(ferr_b),
        .o_parity_err(perr_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        bd = (bd_cnt == BD_DIV - 1);
        bd_cnt = (bd_cnt + 1) % BD_DIV;
    end

    // Counts high cycles, so a stretched done pulse shows up as an extra frame.
    always @(negedge clk) begin
        if (done_a === 1'b1) done0++;
        if (done_b === 1'b1) done1++;
    end

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rx0 = b; else rx1 = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input logic [1:0] stops, input int nstop,
                              input logic par_ovr, input logic par_val);
        logic p;
        p = 1'b0;
        drive_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(which, data[i]);
            p = p ^ data[i];
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(which, par_ovr ? par_val : p);
`else
        if (par_ovr) p = par_val;
`endif
        for (int i = 0; i < nstop; i++) drive_bit(which, stops[i]);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (byte_a !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", byte_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr_a); end
        checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr_a); end
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b expected 00", busy_a, busy_b); end
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (done0 != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL idle_quiet: got done=%0d busy=%b expected 0/0", done0, busy_a); end
    endtask

    task automatic test_basic;
        int d;
        d = done0;
        send_frame(0, 9'h0A5, 8, 2'b01, 1, 1'b0, 1'b0);
        checks++; if (done0 != d + 1) begin errors++; $display("FAIL basic_done: got %0d expected %0d", done0 - d, 1); end
        checks++; if (byte_a !== 8'hA5) begin errors++; $display("FAIL basic_byte: got %h expected a5", byte_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", ferr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_glitch;
        int d;
        d = done0;
        rx0 = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b expected 1", busy_a); end
        repeat (9) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (done0 != d) begin errors++; $display("FAIL glitch_done: got %0d expected 0", done0 - d); end
        checks++; if (byte_a !== 8'hA5 || ferr_a !== 1'b0) begin errors++; $display("FAIL glitch_hold: got %h/%b expected a5/0", byte_a, ferr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", busy_a); end
    endtask

    task automatic test_framing;
        int d;
        d = done0;
        send_frame(0, 9'h03C, 8, 2'b00, 1, 1'b0, 1'b0);
        checks++; if (done0 != d + 1) begin errors++; $display("FAIL ferr_done: got %0d expected 1", done0 - d); end
        checks++; if (byte_a !== 8'h3C) begin errors++; $display("FAIL ferr_byte: got %h expected 3c", byte_a); end
        checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", ferr_a); end
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (done0 != d + 1 || busy_a !== 1'b0) begin errors++; $display("FAIL break_ignored: got done=%0d busy=%b expected 1/0", done0 - d, busy_a); end
        drive_bit(0, 1'b1);
        send_frame(0, 9'h055, 8, 2'b01, 1, 1'b0, 1'b0);
        checks++; if (done0 != d + 2) begin errors++; $display("FAIL ferr_next_done: got %0d expected 2", done0 - d); end
        checks++; if (byte_a !== 8'h55 || ferr_a !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %h/%b expected 55/0", byte_a, ferr_a); end
    endtask

    task automatic test_parity;
        send_frame(0, 9'h007, 8, 2'b01, 1, 1'b1, 1'b1);
        checks++; if (byte_a !== 8'h07) begin errors++; $display("FAIL par_byte: got %h expected 07", byte_a); end
        checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL par_good: got %b expected 0", perr_a); end
`ifdef UART_RX_PARITY_EN
        send_frame(0, 9'h007, 8, 2'b01, 1, 1'b1, 1'b0);
        checks++; if (perr_a !== 1'b1) begin errors++; $display("FAIL par_bad: got %b expected 1", perr_a); end
        checks++; if (byte_a !== 8'h07 || ferr_a !== 1'b0) begin errors++; $display("FAIL par_bad_data: got %h/%b expected 07/0", byte_a, ferr_a); end
`endif
    endtask

    task automatic test_back_to_back;
        int d;
        d = done1;
        send_frame(1, 9'h041, 7, 2'b11, 2, 1'b0, 1'b0);
        checks++; if (done1 != d + 1) begin errors++; $display("FAIL b2b_done1: got %0d expected 1", done1 - d); end
        checks++; if (byte_b !== 7'h41 || ferr_b !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h/%b expected 41/0", byte_b, ferr_b); end
        send_frame(1, 9'h07F, 7, 2'b01, 2, 1'b0, 1'b0);
        checks++; if (done1 != d + 2) begin errors++; $display("FAIL b2b_done2: got %0d expected 2", done1 - d); end
        checks++; if (byte_b !== 7'h7F) begin errors++; $display("FAIL b2b_byte2: got %h expected 7f", byte_b); end
        checks++; if (ferr_b !== 1'b1) begin errors++; $display("FAIL b2b_ferr2: got %b expected 1", ferr_b); end
        drive_bit(1, 1'b1);
    endtask

    task automatic test_reset_midframe;
        int d;
        d = done0;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        repeat (BIT_CLKS / 2) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy_a); end
        rst = 1'b1;
        #1;
        checks++; if (byte_a !== 8'h00 || ferr_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h/%b/%b/%b expected 00/0/0/0", byte_a, ferr_a, busy_a, done_a);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5 * BIT_CLKS) @(negedge clk);
        checks++; if (done0 != d) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", done0 - d); end
        send_frame(0, 9'h012, 8, 2'b01, 1, 1'b0, 1'b0);
        checks++; if (done0 != d + 1) begin errors++; $display("FAIL post_reset_done: got %0d expected 1", done0 - d); end
        checks++; if (byte_a !== 8'h12 || ferr_a !== 1'b0) begin errors++; $display("FAIL post_reset_byte: got %h/%b expected 12/0", byte_a, ferr_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        repeat (BIT_CLKS) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
